// File: rtl/train_case_sequencer.sv
// train_case_sequencer: block-cycle sequencing, feed/case selection and accuracy tracking for DNN training
module train_case_sequencer #(
  parameter int cpc = 18,
  parameter int training_cases = 10000,
  parameter int num_epochs = 10,
  parameter int checklast = 1000,
  parameter int out_par = 1,
  localparam int cw = $clog2(cpc),
  localparam int sw = $clog2(cpc-2),
  localparam int tw = $clog2(training_cases),
  localparam int rw = $clog2(checklast+1),
  localparam int pw = $clog2(checklast)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               hold,
  input  logic [out_par-1:0] a_out_bits,
  input  logic [out_par-1:0] y_out_bits,
  output logic               busy,
  output logic               done,
  output logic               block_start,
  output logic [cw-1:0]      cycle_index,
  output logic [sw-1:0]      sel_network,
  output logic [tw-1:0]      sel_tc,
  output logic               case_valid,
  output logic               case_correct,
  output logic               epoch_end,
  output logic [15:0]        epoch,
  output logic [31:0]        num_train,
  output logic [rw-1:0]      recent,
  output logic [31:0]        total_correct
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
  localparam logic [31:0] total_cases = 32'(training_cases * num_epochs);
  state_t state, state_nx;
  logic err, eob, mismatch, correct, last, restart, tc_wrap;
  logic [pw-1:0] ptr;
  logic [checklast-1:0] win;
  assign mismatch = a_out_bits != y_out_bits;
  assign eob = state == RUN && cycle_index == cw'(cpc-1);
  assign correct = ~(err | mismatch);
  assign last = num_train + 32'd1 == total_cases;
  assign restart = state == DONE && start;
  assign tc_wrap = sel_tc == tw'(training_cases-1);
  // feed select lags the block position by the two pipeline cycles
  assign sel_network = sw'(cycle_index - cw'(2));
  always_ff @(posedge clk) state <= !reset ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? RUN : IDLE;
      RUN:     state_nx = !eob ? RUN : last ? DONE : hold ? PAUSE : RUN;
      PAUSE:   state_nx = hold ? PAUSE : RUN;
      DONE:    state_nx = start ? RUN : DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    busy = state == RUN || state == PAUSE;
    done = state == DONE;
    block_start = state == RUN && cycle_index == '0;
  end
  always_ff @(posedge clk) begin
    if (!reset || restart) begin
      cycle_index <= '0;
      sel_tc <= '0;
      err <= 1'b0;
      case_valid <= 1'b0;
      case_correct <= 1'b0;
      epoch_end <= 1'b0;
      epoch <= '0;
      num_train <= '0;
      recent <= '0;
      total_correct <= '0;
      win <= '0;
      ptr <= '0;
    end else begin
      case_valid <= eob;
      epoch_end <= eob && tc_wrap;
      if (state == RUN) begin
        cycle_index <= eob ? '0 : cycle_index + cw'(1);
        err <= cycle_index == '0 ? 1'b0 : err | (cycle_index >= cw'(2) && mismatch);
      end
      if (eob) begin
        case_correct <= correct;
        num_train <= num_train + 32'd1;
        total_correct <= total_correct + 32'(correct);
        // window slot being overwritten leaves the count as the new result enters
        recent <= recent - rw'(win[ptr]) + rw'(correct);
        win[ptr] <= correct;
        ptr <= ptr == pw'(checklast-1) ? '0 : ptr + pw'(1);
        sel_tc <= tc_wrap ? '0 : sel_tc + tw'(1);
        epoch <= epoch + 16'(tc_wrap);
      end
    end
  end
endmodule

// File: tb/tb_train_case_sequencer.sv
// tb_train_case_sequencer: directed-plus-random bench with a case-history reference model
module tb_train_case_sequencer;
  localparam int CPC = 18, TC = 4, NE = 2, CL = 3, OP = 2;
  logic clk = 1'b0, reset, start, hold;
  logic [OP-1:0] a, y;
  logic busy, done, block_start, case_valid, case_correct, epoch_end;
  logic [4:0] cycle_index;
  logic [3:0] sel_network;
  logic [1:0] sel_tc;
  logic [15:0] epoch;
  logic [31:0] num_train, total_correct;
  logic [1:0] recent;
  int n_total = 0, n_bad = 0, cnt = 0, tot = 0;
  bit hist[$];

  train_case_sequencer #(.cpc(CPC), .training_cases(TC), .num_epochs(NE), .checklast(CL), .out_par(OP)) dut (
    .clk(clk), .reset(reset), .start(start), .hold(hold),
    .a_out_bits(a), .y_out_bits(y),
    .busy(busy), .done(done), .block_start(block_start),
    .cycle_index(cycle_index), .sel_network(sel_network), .sel_tc(sel_tc),
    .case_valid(case_valid), .case_correct(case_correct), .epoch_end(epoch_end),
    .epoch(epoch), .num_train(num_train), .recent(recent), .total_correct(total_correct));

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int recent_exp();
    int s = 0;
    for (int i = 0; i < CL && i < hist.size(); i++) s += int'(hist[hist.size()-1-i]);
    return s;
  endfunction

  task automatic model_clear();
    cnt = 0; tot = 0; hist.delete();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".blk"}, block_start, 0);
    chk({tag, ".ci"}, cycle_index, 0);
    chk({tag, ".seltc"}, sel_tc, 0);
    chk({tag, ".cv"}, case_valid, 0);
    chk({tag, ".cc"}, case_correct, 0);
    chk({tag, ".ee"}, epoch_end, 0);
    chk({tag, ".epoch"}, epoch, 0);
    chk({tag, ".ntr"}, num_train, 0);
    chk({tag, ".recent"}, recent, 0);
    chk({tag, ".tot"}, total_correct, 0);
  endtask

  // one full block cycle: mm = cycle with a mismatch (-1 none), h_at = cycle hold rises, st_at = stray start
  task automatic do_case(input int mm, input int h_at, input int st_at);
    bit ok, fin;
    for (int c = 0; c < CPC; c++) begin
      chk("ci", cycle_index, c);
      chk("seln", sel_network, (c + CPC - 4) % (CPC - 2));
      chk("blk", block_start, c == 0);
      chk("busy", busy, 1);
      chk("seltc", sel_tc, cnt % TC);
      chk("ntr_run", num_train, cnt);
      if (c > 0) chk("cv_run", case_valid, 0);
      a = OP'($urandom);
      y = (c == mm) ? a ^ OP'($urandom_range(1, (1 << OP) - 1)) : a;
      start = (c == st_at);
      hold = (h_at >= 0 && c >= h_at);
      @(negedge clk);
    end
    start = 1'b0;
    ok = !(mm >= 2);
    hist.push_back(ok);
    cnt++;
    tot += int'(ok);
    fin = cnt == TC * NE;
    chk("cv", case_valid, 1);
    chk("cc", case_correct, ok);
    chk("ntr", num_train, cnt);
    chk("tot", total_correct, tot);
    chk("recent", recent, recent_exp());
    chk("seltc_next", sel_tc, cnt % TC);
    chk("epoch", epoch, cnt / TC);
    chk("ee", epoch_end, cnt % TC == 0);
    chk("ci_next", cycle_index, 0);
    chk("done", done, fin);
    chk("busy_next", busy, !fin);
    chk("blk_next", block_start, !fin && !hold);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; hold = 1'b0; a = '0; y = '0;
    repeat (3) @(negedge clk);
    check_zero("rst");
    reset = 1'b1;
    @(negedge clk);
    check_zero("idle");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    model_clear();
    do_case(-1, -1, -1);
    do_case(1, -1, 4);
    do_case(17, -1, -1);
    do_case(-1, 9, -1);
    for (int i = 0; i < 10; i++) begin
      chk("p.busy", busy, 1);
      chk("p.done", done, 0);
      chk("p.ci", cycle_index, 0);
      chk("p.blk", block_start, 0);
      chk("p.ntr", num_train, cnt);
      if (i > 0) chk("p.cv", case_valid, 0);
      if (i == 9) hold = 1'b0;
      @(negedge clk);
    end
    do_case(5, -1, -1);
    do_case(int'($urandom_range(0, CPC)) - 1, -1, -1);
    do_case(int'($urandom_range(0, CPC)) - 1, -1, -1);
    do_case(int'($urandom_range(0, CPC)) - 1, 3, -1);
    for (int i = 0; i < 50; i++) begin
      chk("d.done", done, 1);
      chk("d.busy", busy, 0);
      chk("d.ci", cycle_index, 0);
      chk("d.ntr", num_train, cnt);
      chk("d.tot", total_correct, tot);
      chk("d.recent", recent, recent_exp());
      chk("d.epoch", epoch, NE);
      chk("d.seltc", sel_tc, 0);
      if (i > 0) chk("d.cv", case_valid, 0);
      a = OP'($urandom); y = OP'($urandom);
      if (i == 10) hold = 1'b0;
      @(negedge clk);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    model_clear();
    chk("rs.tot", total_correct, 0);
    chk("rs.recent", recent, 0);
    chk("rs.epoch", epoch, 0);
    chk("rs.cv", case_valid, 0);
    for (int k = 0; k < 5; k++) do_case(int'($urandom_range(0, CPC)) - 1, -1, -1);
    for (int c = 0; c < 9; c++) begin
      chk("mr.ci", cycle_index, c);
      a = OP'($urandom); y = a;
      @(negedge clk);
    end
    chk("mr.ci9", cycle_index, 9);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check_zero("midrst");
    @(negedge clk);
    check_zero("midrst_idle");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    model_clear();
    do_case(-1, -1, -1);
    do_case(int'($urandom_range(0, CPC)) - 1, -1, -1);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
